// File: rtl/stopit_pkg.sv
// Shared types and defaults for the StopIt round controller.
package stopit_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SHOW = 3'd1,
    RUN  = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_e;

endpackage

// File: rtl/stopit_counter.sv
// Up-counter with synchronous clear (priority over enable) and natural wrap.
module stopit_counter
  import stopit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear first, otherwise increment with wrap when enabled.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stopit_ctrl.sv
// StopIt round controller: target capture, flash phase, tick-paced run,
// hit/miss judgement and a saturating win streak.
module stopit_ctrl
  import stopit_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FLASH_TICKS = 4,
  parameter int SCORE_W     = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               tick_i,
  input  logic [WIDTH-1:0]   rand_i,
  output logic               next_o,
  output logic [WIDTH-1:0]   target_o,
  output logic [WIDTH-1:0]   count_o,
  output logic [2:0]         state_o,
  output logic               win_o,
  output logic               lose_o,
  output logic [SCORE_W-1:0] score_o
);

  localparam logic [WIDTH-1:0]   FLASH_LAST = WIDTH'((FLASH_TICKS > 0) ? FLASH_TICKS - 1 : 0);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_e             state_d, state_q;
  logic [WIDTH-1:0]   target_d, target_q;
  logic [SCORE_W-1:0] score_d, score_q;

  logic [WIDTH-1:0]   round_cnt;
  logic [WIDTH-1:0]   flash_cnt;
  logic               start_ok;
  logic               in_run;
  logic               in_show;
  logic               flash_done;

  assign in_run     = (state_q == RUN);
  assign in_show    = (state_q == SHOW);
  assign start_ok   = start_i & ((state_q == IDLE) | (state_q == WIN) | (state_q == LOSE));
  assign flash_done = tick_i & in_show & (flash_cnt == FLASH_LAST);

  // Round counter: a stop in the same cycle as a tick freezes the count.
  stopit_counter #(.WIDTH(WIDTH)) u_round_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_ok),
    .en_i    (tick_i & in_run & ~stop_i),
    .count_o (round_cnt)
  );

  // Flash counter: paces how long the target is shown.
  stopit_counter #(.WIDTH(WIDTH)) u_flash_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (start_ok),
    .en_i    (tick_i & in_show),
    .count_o (flash_cnt)
  );

  // Next state, target capture and streak update.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start_i) begin
          target_d = rand_i;
          state_d  = (FLASH_TICKS == 0) ? RUN : SHOW;
          if (state_q == LOSE) begin
            score_d = '0;
          end
        end
      end
      SHOW: begin
        if (flash_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          if (round_cnt == target_q) begin
            state_d = WIN;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            state_d = LOSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, target and streak registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      target_q <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      score_q  <= score_d;
    end
  end

  assign next_o   = (state_q == IDLE) | (state_q == WIN) | (state_q == LOSE);
  assign target_o = target_q;
  assign count_o  = round_cnt;
  assign state_o  = state_q;
  assign win_o    = (state_q == WIN);
  assign lose_o   = (state_q == LOSE);
  assign score_o  = score_q;

endmodule

// File: tb/tb_stopit_ctrl.sv
// Directed bench for stopit_ctrl with a behavioural round model and a
// per-cycle output comparison, plus a FLASH_TICKS=0 instance.
module tb_stopit_ctrl;
  import stopit_pkg::*;

  localparam int W   = 5;
  localparam int FT  = 4;
  localparam int SW  = 4;
  localparam int MAXS = (1 << SW) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start0, stop, tick;
  logic [W-1:0] rand_v;

  logic         next_o, win_o, lose_o;
  logic [W-1:0] target_o, count_o;
  logic [2:0]   state_o;
  logic [SW-1:0] score_o;

  logic         next0, win0, lose0;
  logic [W-1:0] target0, count0;
  logic [2:0]   state0;
  logic [SW-1:0] score0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopit_ctrl #(.WIDTH(W), .FLASH_TICKS(FT), .SCORE_W(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .tick_i(tick),
    .rand_i(rand_v), .next_o(next_o), .target_o(target_o), .count_o(count_o),
    .state_o(state_o), .win_o(win_o), .lose_o(lose_o), .score_o(score_o)
  );

  stopit_ctrl #(.WIDTH(W), .FLASH_TICKS(0), .SCORE_W(SW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .stop_i(stop), .tick_i(tick),
    .rand_i(rand_v), .next_o(next0), .target_o(target0), .count_o(count0),
    .state_o(state0), .win_o(win0), .lose_o(lose0), .score_o(score0)
  );

  // Behavioural model of the main instance, in plain integers.
  state_e m_state;
  int     m_target, m_count, m_flash, m_score;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = IDLE; m_target = 0; m_count = 0; m_flash = 0; m_score = 0;
    end else begin
      case (m_state)
        SHOW: if (tick) begin
          m_flash = m_flash + 1;
          if (m_flash == FT) m_state = RUN;
        end
        RUN: begin
          if (stop) begin
            if (m_count == m_target) begin
              m_state = WIN;
              if (m_score < MAXS) m_score = m_score + 1;
            end else begin
              m_state = LOSE;
            end
          end else if (tick) begin
            m_count = (m_count + 1) % (1 << W);
          end
        end
        default: if (start) begin
          if (m_state == LOSE) m_score = 0;
          m_target = int'(rand_v);
          m_count  = 0;
          m_flash  = 0;
          m_state  = (FT == 0) ? RUN : SHOW;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("state",  int'(state_o),  int'(m_state));
      chk("target", int'(target_o), m_target);
      chk("count",  int'(count_o),  m_count);
      chk("score",  int'(score_o),  m_score);
      chk("win",    int'(win_o),    int'(m_state == WIN));
      chk("lose",   int'(lose_o),   int'(m_state == LOSE));
      chk("next",   int'(next_o),   int'(m_state == IDLE || m_state == WIN || m_state == LOSE));
    end
  end

  task automatic step(input logic st, input logic sp, input logic tk);
    start = st; stop = sp; tick = tk;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; stop = 1'b0; tick = 1'b0; rand_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_next",  int'(next_o), 1);
    chk("rst_score", int'(score_o), 0);
    rst_n = 1'b1;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("idle_next", int'(next_o), 1);
    chk("idle_win",  int'(win_o), 0);

    // Round 1: target 7, flash 4 ticks, stop at 7 -> win.
    rand_v = 5'd7;
    step(1'b1, 1'b0, 1'b0);
    chk("r1_state_show", int'(state_o), 1);
    chk("r1_target", int'(target_o), 7);
    chk("r1_next_show", int'(next_o), 0);
    rand_v = 5'd20;
    step(1'b1, 1'b1, 1'b0);
    chk("show_ign_state", int'(state_o), 1);
    chk("show_ign_target", int'(target_o), 7);
    ticks(3);
    chk("r1_still_show", int'(state_o), 1);
    ticks(1);
    chk("r1_run", int'(state_o), 2);
    chk("r1_count0", int'(count_o), 0);
    ticks(7);
    chk("r1_count7", int'(count_o), 7);
    step(1'b0, 1'b1, 1'b0);
    chk("r1_win", int'(win_o), 1);
    chk("r1_score", int'(score_o), 1);

    // Round 2: target 3, start+stop at count 4 -> lose, streak held.
    rand_v = 5'd3;
    step(1'b1, 1'b0, 1'b0);
    ticks(4);
    ticks(4);
    chk("r2_count4", int'(count_o), 4);
    rand_v = 5'd22;
    step(1'b1, 1'b1, 1'b0);
    chk("r2_lose", int'(lose_o), 1);
    chk("r2_target_held", int'(target_o), 3);
    chk("r2_score_held", int'(score_o), 1);
    rand_v = 5'd9;
    step(1'b1, 1'b0, 1'b0);
    chk("r3_score_clr", int'(score_o), 0);
    chk("r3_target", int'(target_o), 9);

    // Round 3: wrap after 33 ticks, then stop+tick at 9 -> win, count frozen.
    ticks(4);
    ticks(33);
    chk("wrap_count1", int'(count_o), 1);
    ticks(8);
    step(1'b0, 1'b1, 1'b1);
    chk("st_tick_win", int'(win_o), 1);
    chk("st_tick_count", int'(count_o), 9);
    chk("st_tick_score", int'(score_o), 1);

    // Streak: 14 more wins reach 15, one further win saturates.
    for (int i = 0; i < 14; i++) begin
      rand_v = W'(i % 6);
      step(1'b1, 1'b0, 1'b0);
      ticks(4);
      ticks(i % 6);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("streak15", int'(score_o), 15);
    rand_v = 5'd2;
    step(1'b1, 1'b0, 1'b0);
    ticks(6);
    step(1'b0, 1'b1, 1'b0);
    chk("streak_sat_win", int'(win_o), 1);
    chk("streak_sat", int'(score_o), 15);

    // Asynchronous reset in the middle of RUN.
    rand_v = 5'd5;
    step(1'b1, 1'b0, 1'b0);
    ticks(7);
    chk("pre_rst_count", int'(count_o), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_count", int'(count_o), 0);
    chk("arst_target", int'(target_o), 0);
    chk("arst_score", int'(score_o), 0);
    chk("arst_next", int'(next_o), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // FLASH_TICKS=0 instance: start goes straight to RUN.
    rand_v = 5'd12;
    start0 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    start0 = 1'b0;
    chk("f0_run", int'(state0), 2);
    chk("f0_target", int'(target0), 12);
    chk("f0_count0", int'(count0), 0);
    ticks(2);
    chk("f0_count2", int'(count0), 2);
    step(1'b0, 1'b1, 1'b0);
    chk("f0_lose", int'(lose0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
